// File: rtl/fp_pkg.sv
// Shared definitions for the FP operand datapath: default field widths,
// one-hot class bit positions and the exponent bias helper.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Bit positions inside the one-hot class vector {nan, inf, sub, zero, norm}.
    localparam int CLS_NORM = 0;
    localparam int CLS_ZERO = 1;
    localparam int CLS_SUB  = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_NAN  = 4;

    typedef logic [4:0] cls_t;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_unpack_pipe_if.sv
// Operand-in / unpacked-result-out bundle for fp_unpack_pipe.
// Handshake: a transfer happens on a side in any cycle where valid && ready;
// a raised out_valid holds with stable data until out_ready is seen.
interface fp_unpack_pipe_if #(
    parameter int EXP_W = fp_pkg::EXP_W_DEF,
    parameter int MAN_W = fp_pkg::MAN_W_DEF
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   a;
    logic [EXP_W+MAN_W:0]   b;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign_a;
    logic                   sign_b;
    logic [EXP_W+1:0]       exp_a;
    logic [EXP_W+1:0]       exp_b;
    logic [MAN_W:0]         mant_a;
    logic [MAN_W:0]         mant_b;
    fp_pkg::cls_t           cls_a;
    fp_pkg::cls_t           cls_b;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
               mant_a, mant_b, cls_a, cls_b
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b,
               mant_a, mant_b, cls_a, cls_b
    );
endinterface

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W     = 24,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count
);
    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count = CNT_W'(W - 1 - i);
            end
        end
    end
endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage valid/ready operand unpacker: S1 holds raw operands, S2 holds
// sign/exponent/mantissa/class. Define FP_UNPACK_NORM_EN to normalise subnormals.
module fp_unpack_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fp_unpack_pipe_if.slave io
);
    localparam int OP_W  = 1 + EXP_W + MAN_W;
    localparam int RES_W = 1 + (EXP_W + 2) + (MAN_W + 1) + 5;
`ifdef FP_UNPACK_NORM_EN
    localparam int LZ_W  = $clog2(MAN_W + 2);
`endif

    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [RES_W-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
    logic [RES_W-1:0] unp_a, unp_b;
    logic             s2_advance;
    logic             in_ready;

    // Result layout: {sign, exp[EXP_W+1:0], mant[MAN_W:0], cls[4:0]}.
    function automatic logic [RES_W-1:0] unpack(
        input logic [OP_W-1:0] op
`ifdef FP_UNPACK_NORM_EN
        , input logic [LZ_W-1:0] lz
`endif
    );
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic [EXP_W+1:0] ex;
        logic [MAN_W:0]   m;
        cls_t             cls;
        e   = op[MAN_W +: EXP_W];
        f   = op[MAN_W-1:0];
        ex  = '0;
        m   = '0;
        cls = '0;
        if (e == '0 && f == '0) begin
            cls[CLS_ZERO] = 1'b1;
        end else if (e == '0) begin
            cls[CLS_SUB] = 1'b1;
`ifdef FP_UNPACK_NORM_EN
            m  = {1'b0, f} << lz;
            ex = (EXP_W+2)'(1) - (EXP_W+2)'(lz);
`else
            m  = {1'b0, f};
            ex = (EXP_W+2)'(1);
`endif
        end else if (e == '1) begin
            cls[(f == '0) ? CLS_INF : CLS_NAN] = 1'b1;
            ex = {2'b00, e};
            m  = {1'b1, f};
        end else begin
            cls[CLS_NORM] = 1'b1;
            ex = {2'b00, e};
            m  = {1'b1, f};
        end
        return {op[OP_W-1], ex, m, cls};
    endfunction

`ifdef FP_UNPACK_NORM_EN
    logic [LZ_W-1:0] lz_a, lz_b;

    fp_lzc #(.W(MAN_W + 1), .CNT_W(LZ_W)) u_lzc_a (
        .din   ({1'b0, a_q[MAN_W-1:0]}),
        .count (lz_a)
    );

    fp_lzc #(.W(MAN_W + 1), .CNT_W(LZ_W)) u_lzc_b (
        .din   ({1'b0, b_q[MAN_W-1:0]}),
        .count (lz_b)
    );

    assign unp_a = unpack(a_q, lz_a);
    assign unp_b = unpack(b_q, lz_b);
`else
    assign unp_a = unpack(a_q);
    assign unp_b = unpack(b_q);
`endif

    always_comb begin
        s2_advance  = !out_valid_q || io.out_ready;
        in_ready    = !rst && (!s1_valid_q || s2_advance);

        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;

        // S1 either takes a new pair or drains into S2 whenever it is ready.
        if (in_ready) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                a_d = io.a;
                b_d = io.b;
            end
        end

        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_a_d = unp_a;
                res_b_d = unp_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.sign_a    = res_a_q[RES_W-1];
    assign io.exp_a     = res_a_q[MAN_W+6 +: EXP_W+2];
    assign io.mant_a    = res_a_q[5 +: MAN_W+1];
    assign io.cls_a     = res_a_q[4:0];
    assign io.sign_b    = res_b_q[RES_W-1];
    assign io.exp_b     = res_b_q[MAN_W+6 +: EXP_W+2];
    assign io.mant_b    = res_b_q[5 +: MAN_W+1];
    assign io.cls_b     = res_b_q[4:0];

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe (single precision): directed steps plus a random
// back-pressure soak against an arithmetic reference model.
module tb_fp_unpack_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int errors    = 0;
    int acc_count = 0;
    int out_count = 0;

    logic [79:0] exp_q[$];

    fp_unpack_pipe_if #(.EXP_W(8), .MAN_W(23)) io ();

    fp_unpack_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {sign, exp[9:0], mant[23:0], cls[4:0]} for one binary32 operand.
    function automatic logic [39:0] ref_res(input logic [31:0] op);
        logic [7:0]  e;
        logic [22:0] f;
        int          ex;
        logic [23:0] m;
        logic [4:0]  c;
        e = op[30:23];
        f = op[22:0];
        if (e == 8'd0 && f == 23'd0) begin
            c = 5'b00010; ex = 0; m = 24'd0;
        end else if (e == 8'd0) begin
            c = 5'b00100;
            m = {1'b0, f};
            ex = 1;
`ifdef FP_UNPACK_NORM_EN
            while (m < 24'h800000) begin
                m  = m * 2;
                ex = ex - 1;
            end
`endif
        end else if (e == 8'hFF) begin
            c = (f == 23'd0) ? 5'b01000 : 5'b10000;
            ex = 255;
            m = 24'h800000 + {1'b0, f};
        end else begin
            c = 5'b00001;
            ex = int'(e);
            m = 24'h800000 + {1'b0, f};
        end
        return {op[31], 10'(ex), m, c};
    endfunction

    function automatic logic [79:0] obs_pack();
        return {io.sign_a, io.exp_a, io.mant_a, io.cls_a,
                io.sign_b, io.exp_b, io.mant_b, io.cls_b};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 3))
            0:       f = 23'd0;
            1:       f = 23'd1 << $urandom_range(0, 22);
            default: f = 23'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (io.out_ready)
                chk("in_ready_with_out_ready", io.in_ready, 1);
            if (io.out_valid && io.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
                else                   chk("scoreboard", obs_pack(), exp_q.pop_front());
            end
            if (io.in_valid && io.in_ready) begin
                acc_count++;
                exp_q.push_back({ref_res(io.a), ref_res(io.b)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_one(input logic [31:0] av, input logic [31:0] bv);
        io.in_valid  = 1'b1;
        io.a         = av;
        io.b         = bv;
        io.out_ready = 1'b1;
        step();
        io.in_valid = 1'b0;
        chk("latency_cycle1_idle", io.out_valid, 0);
        step();
        chk("latency_cycle2_valid", io.out_valid, 1);
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        bit acc;
        int n;
        io.in_valid = 1'b1;
        io.a = av;
        io.b = bv;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = io.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || io.out_valid) && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_out_idle"}, io.out_valid, 0);
    endtask

    // ---------------- directed and random stimulus ----------------
    logic [31:0] bp_a[5];
    logic [31:0] bp_b[5];
    int          base;
    int          cycles;

    initial begin
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.out_ready = 1'b0;
        rst          = 1'b1;
        #2;
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_in_ready", io.in_ready, 0);
        chk("reset_outputs_zero", obs_pack(), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("in_ready_after_release", io.in_ready, 1);

        // Normal operands
        run_one(32'h3F800000, 32'hC0490FDB);
        chk("norm_sign_a", io.sign_a, 0);
        chk("norm_exp_a", io.exp_a, 10'd127);
        chk("norm_mant_a", io.mant_a, 24'h800000);
        chk("norm_cls_a", io.cls_a, 5'b00001);
        chk("norm_sign_b", io.sign_b, 1);
        chk("norm_exp_b", io.exp_b, 10'd128);
        chk("norm_mant_b", io.mant_b, 24'hC90FDB);

        // Zero and infinity
        run_one(32'h00000000, 32'h7F800000);
        chk("zero_cls_a", io.cls_a, 5'b00010);
        chk("zero_exp_a", io.exp_a, 10'd0);
        chk("zero_mant_a", io.mant_a, 24'd0);
        chk("inf_cls_b", io.cls_b, 5'b01000);
        chk("inf_exp_b", io.exp_b, 10'd255);

        // NaN payload
        run_one(32'h7FC00001, 32'h3F800000);
        chk("nan_cls_a", io.cls_a, 5'b10000);
        chk("nan_mant_a", io.mant_a, 24'hC00001);

        // Smallest subnormal
        run_one(32'h00000001, 32'h80400000);
        chk("sub_cls_a", io.cls_a, 5'b00100);
`ifdef FP_UNPACK_NORM_EN
        chk("sub_exp_a", io.exp_a, 10'h3EA);   // -22
        chk("sub_mant_a", io.mant_a, 24'h800000);
        chk("sub_exp_b", io.exp_b, 10'd0);
        chk("sub_mant_b", io.mant_b, 24'h800000);
`else
        chk("sub_exp_a", io.exp_a, 10'd1);
        chk("sub_mant_a", io.mant_a, 24'h000001);
        chk("sub_exp_b", io.exp_b, 10'd1);
        chk("sub_mant_b", io.mant_b, 24'h400000);
`endif
        drain("directed");

        // Back-pressure: 5 pairs, output stalled for 3 cycles after filling
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rand_op();
            bp_b[i] = rand_op();
        end
        base = out_count;
        io.out_ready = 1'b0;
        send(bp_a[0], bp_b[0]);
        send(bp_a[1], bp_b[1]);
        io.a = bp_a[2];
        io.b = bp_b[2];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", io.in_ready, 0);
            chk("bp_out_valid_held", io.out_valid, 1);
            chk("bp_data_stable", obs_pack(), {ref_res(bp_a[0]), ref_res(bp_b[0])});
            @(posedge clk);
            #1;
        end
        io.out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(bp_a[i], bp_b[i]);
        drain("bp");
        chk("bp_emit_count", out_count - base, 5);

        // Reset with two pairs in flight
        io.out_ready = 1'b0;
        send(rand_op(), rand_op());
        send(rand_op(), rand_op());
        io.in_valid = 1'b0;
        step();
        chk("rst_mid_full_before", io.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", io.out_valid, 0);
        chk("rst_mid_outputs_zero", obs_pack(), 0);
        chk("rst_mid_in_ready", io.in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready_release", io.in_ready, 1);
        io.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_mid_no_stale", io.out_valid, 0);
        end

        // Random back-pressure soak
        base = acc_count;
        cycles = 0;
        while ((acc_count - base) < 10000 && cycles < 60000) begin
            io.in_valid  = ($urandom_range(0, 9) < 7);
            io.a         = rand_op();
            io.b         = rand_op();
            io.out_ready = ($urandom_range(0, 9) < 7);
            step();
            cycles++;
        end
        chk("soak_accepts", acc_count - base, 10000);
        drain("soak");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
